// File: rtl/softmax_sequencer_if.sv
// Handshake and data bus between the softmax sequencer and its datapath/consumer.
// Latency: none (wires only).
// Backpressure: out_valid/out_ready on the result vector; start is sampled only when idle.
interface softmax_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM        = 10
);
  logic                      start;
  logic [NUM*DATA_WIDTH-1:0] in_data;
  logic                      busy;
  logic                      exp_reset;
  logic [DATA_WIDTH-1:0]     exp_operand;
  logic [DATA_WIDTH-1:0]     exp_result;
  logic                      acc_clear;
  logic [DATA_WIDTH-1:0]     acc_operand;
  logic [DATA_WIDTH-1:0]     acc_sum;
  logic                      div_start;
  logic [NUM*DATA_WIDTH-1:0] div_numer;
  logic [DATA_WIDTH-1:0]     div_denom;
  logic [NUM-1:0]            div_done;
  logic [NUM*DATA_WIDTH-1:0] div_result;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM*DATA_WIDTH-1:0] out_data;
  logic                      err;

  // Sequencer side.
  modport slave (
    input  start, in_data, exp_result, acc_sum, div_done, div_result, out_ready,
    output busy, exp_reset, exp_operand, acc_clear, acc_operand,
           div_start, div_numer, div_denom, out_valid, out_data, err
  );

  // Controller / datapath / consumer side.
  modport master (
    output start, in_data, exp_result, acc_sum, div_done, div_result, out_ready,
    input  busy, exp_reset, exp_operand, acc_clear, acc_operand,
           div_start, div_numer, div_denom, out_valid, out_data, err
  );
endinterface

// File: rtl/softmax_sequencer.sv
// Softmax sequencer: shares one exponent unit over NUM lanes, feeds the accumulator, launches dividers, returns the vector.
// Latency: NUM*(EXP_LAT+2)+ACC_LAT+1 cycles to div_start, then last div_done + 1 to out_valid (or DIV_TIMEOUT wait cycles).
// Backpressure: result held in OUT until out_ready; start is ignored (not queued) while busy.
module softmax_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM         = 10,
  parameter int EXP_LAT     = 10,
  parameter int ACC_LAT     = 1,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  softmax_sequencer_if.slave   bus
);

  localparam int LW   = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int M1   = (EXP_LAT > DIV_TIMEOUT) ? EXP_LAT : DIV_TIMEOUT;
  localparam int M2   = (ACC_LAT > NUM) ? ACC_LAT : NUM;
  localparam int CMAX = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [LW-1:0] LAST_LANE = LW'(NUM - 1);
  localparam logic [LW-1:0] LANE_ONE  = LW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] EXP_LAT_C = CW'(EXP_LAT);
  localparam logic [CW-1:0] ACC_LAT_C = CW'(ACC_LAT);
  localparam logic [CW-1:0] TMO_C     = CW'(DIV_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_EXP_LOAD, S_EXP_RUN, S_ACC, S_ACC_SETTLE, S_DIV_START, S_DIV_WAIT, S_OUT
  } state_t;

  state_t                             state_q;
  logic [LW-1:0]                      lane_q;
  logic [CW-1:0]                      cnt_q;
  logic [NUM-1:0]                     mask_q;
  logic [NUM-1:0]                     mask_d;
  logic [LW-1:0]                      lane_inc;
  logic [NUM-1:0][DATA_WIDTH-1:0]     in_q;
  logic [NUM-1:0][DATA_WIDTH-1:0]     buf_q;
  logic [NUM-1:0][DATA_WIDTH-1:0]     out_data_q;
  logic                               busy_q;
  logic                               exp_reset_q;
  logic [DATA_WIDTH-1:0]              exp_operand_q;
  logic                               acc_clear_q;
  logic [DATA_WIDTH-1:0]              acc_operand_q;
  logic                               div_start_q;
  logic [DATA_WIDTH-1:0]              div_denom_q;
  logic                               out_valid_q;
  logic                               err_q;

  assign lane_inc = lane_q + LANE_ONE;

  // Completion mask including the lanes reporting done in the current cycle.
  always_comb begin
    mask_d = mask_q | bus.div_done;
  end

  // Sequencing FSM; every output is registered and set on entry to the state that owns it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      lane_q        <= '0;
      cnt_q         <= '0;
      mask_q        <= '0;
      in_q          <= '0;
      buf_q         <= '0;
      out_data_q    <= '0;
      busy_q        <= 1'b0;
      exp_reset_q   <= 1'b1;
      exp_operand_q <= '0;
      acc_clear_q   <= 1'b1;
      acc_operand_q <= '0;
      div_start_q   <= 1'b0;
      div_denom_q   <= '0;
      out_valid_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      div_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            in_q          <= bus.in_data;
            lane_q        <= '0;
            busy_q        <= 1'b1;
            exp_reset_q   <= 1'b1;
            exp_operand_q <= bus.in_data[DATA_WIDTH-1:0];
            state_q       <= S_EXP_LOAD;
          end
        end
        S_EXP_LOAD: begin
          exp_reset_q <= 1'b0;
          cnt_q       <= CNT_ONE;
          state_q     <= S_EXP_RUN;
        end
        S_EXP_RUN: begin
          if (cnt_q == EXP_LAT_C) begin
            buf_q[lane_q] <= bus.exp_result;
            exp_reset_q   <= 1'b1;
            if (lane_q == LAST_LANE) begin
              // Lane 0 was captured long ago, so the first operand is ready now.
              lane_q        <= '0;
              acc_clear_q   <= 1'b0;
              acc_operand_q <= buf_q[0];
              state_q       <= S_ACC;
            end else begin
              lane_q        <= lane_inc;
              exp_operand_q <= in_q[lane_inc];
              state_q       <= S_EXP_LOAD;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_ACC: begin
          if (lane_q == LAST_LANE) begin
            acc_operand_q <= '0;
            if (ACC_LAT == 0) begin
              div_denom_q <= bus.acc_sum;
              div_start_q <= 1'b1;
              acc_clear_q <= 1'b1;
              mask_q      <= '0;
              out_data_q  <= '0;
              state_q     <= S_DIV_START;
            end else begin
              cnt_q   <= CNT_ONE;
              state_q <= S_ACC_SETTLE;
            end
          end else begin
            lane_q        <= lane_inc;
            acc_operand_q <= buf_q[lane_inc];
          end
        end
        S_ACC_SETTLE: begin
          if (cnt_q == ACC_LAT_C) begin
            div_denom_q <= bus.acc_sum;
            div_start_q <= 1'b1;
            acc_clear_q <= 1'b1;
            mask_q      <= '0;
            out_data_q  <= '0;
            state_q     <= S_DIV_START;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_DIV_START: begin
          // div_done seen here may be stale from a previous pass, so it is ignored.
          cnt_q   <= CNT_ONE;
          state_q <= S_DIV_WAIT;
        end
        S_DIV_WAIT: begin
          for (int i = 0; i < NUM; i++) begin
            if (bus.div_done[i] && !mask_q[i]) begin
              out_data_q[i] <= bus.div_result[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          mask_q <= mask_d;
          if (&mask_d) begin
            out_valid_q <= 1'b1;
            err_q       <= 1'b0;
            state_q     <= S_OUT;
          end else if (cnt_q == TMO_C) begin
            // Lanes that never finished keep the zero written at DIV_START.
            out_valid_q <= 1'b1;
            err_q       <= 1'b1;
            state_q     <= S_OUT;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.exp_reset   = exp_reset_q;
  assign bus.exp_operand = exp_operand_q;
  assign bus.acc_clear   = acc_clear_q;
  assign bus.acc_operand = acc_operand_q;
  assign bus.div_start   = div_start_q;
  assign bus.div_numer   = buf_q;
  assign bus.div_denom   = div_denom_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_softmax_sequencer.sv
// Directed bench for softmax_sequencer with fixed-latency exponent/accumulator models and scripted divider completions.
// Latency: checks the absolute cycle of each phase relative to the start sample.
// Backpressure: exercises out_ready held low in OUT and start pulses while busy.
`timescale 1ns/1ps
module tb_softmax_sequencer;
  localparam int DW          = 32;
  localparam int NUM         = 10;
  localparam int EXP_LAT     = 10;
  localparam int ACC_LAT     = 1;
  localparam int DIV_TIMEOUT = 64;
  localparam int W           = NUM * DW;
  localparam int ACC0        = NUM * (EXP_LAT + 1) + 1;
  localparam int T0          = NUM * (EXP_LAT + 2) + ACC_LAT + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  softmax_sequencer_if #(.DATA_WIDTH(DW), .NUM(NUM)) bus ();

  softmax_sequencer #(
    .DATA_WIDTH(DW), .NUM(NUM), .EXP_LAT(EXP_LAT), .ACC_LAT(ACC_LAT), .DIV_TIMEOUT(DIV_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc      = 0;
  int           done_at [NUM];
  logic         done_level;
  logic [W-1:0] in_vec;
  logic [W-1:0] exp_out;

  function automatic logic [DW-1:0] exp_fn(input logic [DW-1:0] x);
    return x ^ 32'h00A5_5A00;
  endfunction

  function automatic logic [DW-1:0] res_val(input int k);
    return 32'h3DCC_CCCD + 32'(k);
  endfunction

  // Exponent unit model: result is valid only on its EXP_LAT-th cycle out of reset.
  int ecnt = 0;
  always @(posedge clk) begin
    if (bus.exp_reset) ecnt <= 0;
    else               ecnt <= ecnt + 1;
  end
  assign bus.exp_result = (!bus.exp_reset && ecnt == EXP_LAT - 1) ? exp_fn(bus.exp_operand) : 32'hBAD0_BAD0;

  // Accumulator model: registered running sum while not cleared.
  logic [DW-1:0] acc_q = '0;
  always @(posedge clk) begin
    if (bus.acc_clear) acc_q <= '0;
    else               acc_q <= acc_q + bus.acc_operand;
  end
  assign bus.acc_sum = acc_q;

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h want %h", tag, cyc, act, exp);
    end
  endtask

  task automatic drive_div();
    for (int k = 0; k < NUM; k++) begin
      logic hit;
      hit = (done_at[k] >= 0) && (done_level ? (cyc >= done_at[k]) : (cyc == done_at[k]));
      bus.div_done[k] = hit;
      bus.div_result[k*DW +: DW] = (done_at[k] >= 0 && cyc >= done_at[k]) ? res_val(k) : 32'hDEAD_BEEF;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    drive_div();
  endtask

  // Start is sampled at the edge ending cycle 0; afterwards the bench sits in cycle 1.
  task automatic kick();
    bus.in_data = in_vec;
    bus.start   = 1'b1;
    cyc         = 0;
    drive_div();
    tick();
    bus.start   = 1'b0;
    bus.in_data = ~in_vec;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_busy"},     bus.busy,        1'b0);
    check_eq({tag, "_exp_rst"},  bus.exp_reset,   1'b1);
    check_eq({tag, "_exp_op"},   bus.exp_operand, '0);
    check_eq({tag, "_acc_clr"},  bus.acc_clear,   1'b1);
    check_eq({tag, "_acc_op"},   bus.acc_operand, '0);
    check_eq({tag, "_div_st"},   bus.div_start,   1'b0);
    check_eq({tag, "_numer"},    bus.div_numer,   '0);
    check_eq({tag, "_denom"},    bus.div_denom,   '0);
    check_eq({tag, "_valid"},    bus.out_valid,   1'b0);
    check_eq({tag, "_data"},     bus.out_data,    '0);
    check_eq({tag, "_err"},      bus.err,         1'b0);
  endtask

  task automatic run_pass(input int exp_ov, input logic exp_err, input int hold);
    int            ds_first;
    int            ds_cnt;
    int            ov_first;
    int            ln;
    logic [W-1:0]  fvec;
    logic [DW-1:0] fsum;
    fsum = '0;
    for (int k = 0; k < NUM; k++) begin
      fvec[k*DW +: DW] = exp_fn(in_vec[k*DW +: DW]);
      fsum = fsum + fvec[k*DW +: DW];
    end
    bus.out_ready = (hold == 0);
    kick();
    ds_first = -1;
    ds_cnt   = 0;
    ov_first = -1;
    while (1) begin
      if (cyc == 1) check_eq("busy_rise", bus.busy, 1'b1);
      if (cyc == 2) check_eq("exp_release", bus.exp_reset, 1'b0);
      if (cyc <= 1 + (NUM - 1) * (EXP_LAT + 1) && (cyc - 1) % (EXP_LAT + 1) == 0) begin
        ln = (cyc - 1) / (EXP_LAT + 1);
        check_eq("exp_load_rst", bus.exp_reset, 1'b1);
        check_eq("exp_operand", bus.exp_operand, in_vec[ln*DW +: DW]);
      end
      if (cyc >= ACC0 && cyc < ACC0 + NUM) begin
        check_eq("acc_clear_low", bus.acc_clear, 1'b0);
        check_eq("acc_operand", bus.acc_operand, fvec[(cyc - ACC0)*DW +: DW]);
      end
      if (cyc == ACC0 + NUM) begin
        check_eq("settle_clear", bus.acc_clear, 1'b0);
        check_eq("settle_operand", bus.acc_operand, '0);
      end
      if (bus.div_start === 1'b1) begin
        if (ds_first < 0) ds_first = cyc;
        ds_cnt++;
        check_eq("div_denom", bus.div_denom, fsum);
        check_eq("div_numer", bus.div_numer, fvec);
        check_eq("acc_clear_back", bus.acc_clear, 1'b1);
      end
      if (bus.out_valid === 1'b1) begin
        ov_first = cyc;
        break;
      end
      if (cyc >= 400) break;
      tick();
    end
    check_eq("div_start_cycle", ds_first, T0);
    check_eq("div_start_pulses", ds_cnt, 1);
    check_eq("out_valid_cycle", ov_first, exp_ov);
    check_eq("err", bus.err, exp_err);
    check_eq("out_data", bus.out_data, exp_out);
    check_eq("busy_in_out", bus.busy, 1'b1);
    if (hold > 0) begin
      bus.start = 1'b1;
      for (int h = 0; h < hold; h++) begin
        tick();
        check_eq("hold_valid", bus.out_valid, 1'b1);
        check_eq("hold_data", bus.out_data, exp_out);
      end
      bus.start     = 1'b0;
      bus.out_ready = 1'b1;
      check_eq("xfer_valid", bus.out_valid, 1'b1);
    end
    tick();
    check_eq("post_valid", bus.out_valid, 1'b0);
    check_eq("post_busy", bus.busy, 1'b0);
    check_eq("post_err", bus.err, 1'b0);
    tick();
    check_eq("start_not_queued", bus.busy, 1'b0);
  endtask

  task automatic set_done_all(input int at);
    for (int k = 0; k < NUM; k++) begin
      done_at[k] = at;
      exp_out[k*DW +: DW] = res_val(k);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle %0d: got no finish want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data   = '0;
    done_level    = 1'b0;
    in_vec        = '0;
    exp_out       = '0;
    for (int k = 0; k < NUM; k++) done_at[k] = -1;
    drive_div();
    tick(); tick(); tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();
    check_reset_vals("idle");

    // Nominal: all lanes 1.0, every divider done together at 147.
    for (int k = 0; k < NUM; k++) in_vec[k*DW +: DW] = 32'h3F80_0000;
    set_done_all(147);
    run_pass(148, 1'b0, 0);

    // Staggered single-cycle done pulses, distinct lane inputs.
    for (int k = 0; k < NUM; k++) begin
      in_vec[k*DW +: DW] = 32'h4000_0000 + (32'(k) << 20);
      done_at[k] = 125 + 2 * k;
      exp_out[k*DW +: DW] = res_val(k);
    end
    run_pass(144, 1'b0, 0);

    // Lane 3 never completes: timeout with that lane zeroed.
    set_done_all(130);
    done_at[3] = -1;
    exp_out[3*DW +: DW] = '0;
    run_pass(187, 1'b1, 0);

    // div_done held high throughout, plus 20 cycles of backpressure with start pulsed in OUT.
    done_level = 1'b1;
    set_done_all(0);
    run_pass(T0 + 2, 1'b0, 20);
    done_level = 1'b0;

    // Reset mid-exponent phase and again mid-divider wait.
    for (int k = 0; k < NUM; k++) in_vec[k*DW +: DW] = 32'h3F80_0000;
    set_done_all(147);
    kick();
    while (cyc < 60) tick();
    check_eq("busy_at_60", bus.busy, 1'b1);
    reset = 1'b1;
    tick();
    check_reset_vals("rst60");
    reset = 1'b0;
    kick();
    while (cyc < 130) tick();
    check_eq("busy_at_130", bus.busy, 1'b1);
    reset = 1'b1;
    tick();
    check_reset_vals("rst130");
    reset = 1'b0;
    tick();
    run_pass(148, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/softmax_sequencer.md
# softmax_sequencer

Handshake-driven sequencer for the softmax datapath. It time-multiplexes one exponent unit across `NUM` inputs, streams the buffered exponents into the accumulator, and launches the `NUM` parallel dividers with the accumulated denominator. It collects the per-lane quotients and presents the result vector through a valid/ready output. It replaces free-running global-counter scheduling with an explicit FSM, start/busy control and divider completion tracking.

## Interface
- `DATA_WIDTH`, 32, width of one IEEE-754 single-precision word
- `NUM`, 10, number of softmax lanes (2..16)
- `EXP_LAT`, 10, cycles from exponent-unit reset release to a valid `exp_result` (>=1)
- `ACC_LAT`, 1, settle cycles after the last accumulator operand before `acc_sum` is valid (>=0)
- `DIV_TIMEOUT`, 64, maximum cycles spent in DIV_WAIT before aborting
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin a softmax pass; sampled only in IDLE
- `in_data`  in  NUM*DATA_WIDTH  lane i at `[i*DATA_WIDTH +: DATA_WIDTH]`; captured in the `start` cycle
- `busy`  out  1  high in every state except IDLE
- `exp_reset`  out  1  exponent-unit reset (high = hold in reset)
- `exp_operand`  out  DATA_WIDTH  current exponent input
- `exp_result`  in  DATA_WIDTH  exponent-unit output
- `acc_clear`  out  1  accumulator clear (high = clear/hold, low = accumulate)
- `acc_operand`  out  DATA_WIDTH  accumulator input; 0 when not feeding
- `acc_sum`  in  DATA_WIDTH  accumulator result
- `div_start`  out  1  one-cycle pulse launching all dividers
- `div_numer`  out  NUM*DATA_WIDTH  buffered exponents, one per divider
- `div_denom`  out  DATA_WIDTH  latched denominator
- `div_done`  in  NUM  per-lane completion; pulse or level
- `div_result`  in  NUM*DATA_WIDTH  per-lane quotients
- `out_valid`  out  1  result vector valid
- `out_ready`  in  1  consumer accepts result
- `out_data`  out  NUM*DATA_WIDTH  softmax result
- `err`  out  1  qualifies `out_valid`; high = divider timeout

## Operation
- Reset values: `busy`=0, `exp_reset`=1, `exp_operand`=0, `acc_clear`=1, `acc_operand`=0, `div_start`=0, `div_numer`=0, `div_denom`=0, `out_valid`=0, `out_data`=0, `err`=0. State = IDLE, lane index = 0, done mask = 0.
- IDLE: when `start`=1, latch `in_data` and go to EXP_LOAD with lane index 0. Otherwise stay.
- EXP_LOAD (1 cycle): `exp_reset`=1, `exp_operand`=lane i of the latched input. Go to EXP_RUN with the counter at 1.
- EXP_RUN (`EXP_LAT` cycles): `exp_reset`=0 and `exp_operand` held. In the cycle where the counter equals `EXP_LAT`, capture `exp_result` into buffer[i]. Then go to EXP_LOAD(i+1), or to ACC when i=NUM-1.
- ACC (`NUM` cycles): `acc_clear`=0, `acc_operand`=buffer[j] for j=0..NUM-1, one per cycle.
- ACC_SETTLE (`ACC_LAT` cycles; skipped when 0): `acc_clear`=0, `acc_operand`=0. On exit, latch `acc_sum` into `div_denom`.
- DIV_START (1 cycle): `div_start`=1 and the done mask is cleared. `div_done` bits seen in this cycle or earlier are ignored.
- DIV_WAIT: each cycle, set mask[i] and capture `div_result` lane i into `out_data` wherever `div_done[i]`=1 and mask[i]=0.
  - When the mask is all ones (including the bits set this cycle), go to OUT with `err`=0.
  - If the wait counter reaches `DIV_TIMEOUT` first, go to OUT with `err`=1. Lanes not yet done output 0.
- OUT: `out_valid`=1. `out_data` and `err` are stable while `out_ready`=0. A transfer happens on a cycle with `out_valid`=1 and `out_ready`=1. The next state is IDLE, and `out_valid`, `err` and `busy` fall the following cycle.
- `acc_clear` returns to 1 from DIV_START onward. `div_numer` holds the buffer contents from the end of ACC until the next start.
- `start` outside IDLE is ignored. It is not queued.
- `reset` in any state wins over all other inputs and returns to reset values the next cycle. In-flight data is discarded.

## Timing
- Let `start` be sampled in cycle 0.
  - Lane i EXP_LOAD occurs at cycle 1+i*(EXP_LAT+1); its capture occurs at (i+1)*(EXP_LAT+1).
  - ACC spans cycles NUM*(EXP_LAT+1)+1 .. NUM*(EXP_LAT+1)+NUM.
  - `div_start` is high at cycle T0 = NUM*(EXP_LAT+2)+ACC_LAT+1.
- If the last `div_done` arrives in cycle T0+D (D>=1), `out_valid` rises at T0+D+1.
- Defaults: capture of lane 0 at cycle 11, ACC at cycles 111..120, `div_start` at cycle 122.
- `busy` rises in cycle 1 and falls the cycle after the transfer.

## Test plan
- Defaults, 10 lanes of 0x3F800000 (1.0), bench models with fixed latency, every `div_done` at cycle 147 -> `div_start` only at cycle 122, `out_valid` rises at cycle 148, `err`=0, `out_data` equals the captured `div_result`.
- Staggered `div_done` (lane k at cycle 125+2k), single-cycle pulses -> every lane captured, `out_valid` at cycle 144.
- `div_done[3]` never asserted, `DIV_TIMEOUT`=64 -> OUT entered at cycle 187, `err`=1, lane 3 = 0, other lanes correct.
- `out_ready`=0 for 20 cycles in OUT -> `out_valid` and data held; transfer on the first ready cycle; `start` asserted during OUT is ignored.
- `reset` asserted at cycle 60 and at cycle 130 -> the next cycle shows all reset values and state IDLE; a fresh `start` reproduces the nominal timing.
- `div_done`=all ones held before and through DIV_START -> no early exit; OUT is entered at T0+2 only because of the bits sampled in DIV_WAIT.
